// File: rtl/du_xmodem_tx.sv
// XMODEM (checksum variant) transmitter: streams a source byte range to the host as
// 128-byte SOH blocks over the UART FIFO ports, handling ACK/NAK/CAN, timeouts and retries.
module du_xmodem_tx #(
    parameter int unsigned NB_UART_DATA   = 8,
    parameter int unsigned NB_ADDR        = 16,
    parameter int unsigned NB_LEN         = 16,
    parameter int unsigned MAX_RETRY      = 10,
    parameter int unsigned NB_TIMEOUT     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [NB_ADDR-1:0]      i_base_addr,
    input  logic [NB_LEN-1:0]       i_nbytes,
    output logic [NB_ADDR-1:0]      o_src_addr,
    input  logic [7:0]              i_src_data,
    output logic                    o_uart_wr,
    output logic [NB_UART_DATA-1:0] o_uart_wdata,
    output logic                    o_uart_tx_start,
    input  logic                    i_uart_tx_done,
    input  logic [NB_UART_DATA-1:0] i_uart_rx_data,
    input  logic                    i_uart_rx_done,
    output logic                    o_uart_rd,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error
);
    // One extra bit so block offsets past a full-range length never wrap.
    localparam int unsigned NB_OFF   = NB_LEN + 1;
    localparam int unsigned NB_RETRY = $clog2(MAX_RETRY + 1);

    localparam logic [7:0] SOH = 8'h01;
    localparam logic [7:0] EOT = 8'h04;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam logic [7:0] CAN = 8'h18;
    localparam logic [7:0] PAD = 8'h1A;

    typedef enum logic [3:0] {
        StIdle, StWaitNak, StSendHdr, StFetch, StSendData,
        StSendCksum, StWaitResp, StSendEot, StWaitEotAck
    } state_e;

    typedef enum logic [1:0] {TxWr, TxStart, TxWait} tx_ph_e;

    state_e              state_q, state_d, resend_st;
    tx_ph_e              tx_ph_q, tx_ph_d;
    logic [NB_ADDR-1:0]  base_q, base_d;
    logic [NB_LEN-1:0]   len_q, len_d;
    logic [NB_OFF-1:0]   blk_off_q, blk_off_d, cur_off, nxt_off;
    logic [7:0]          blk_q, blk_d;
    logic [6:0]          idx_q, idx_d;
    logic [7:0]          byte_q, byte_d;
    logic [7:0]          cksum_q, cksum_d;
    logic [NB_RETRY-1:0] retry_q, retry_d, retry_inc;
    logic [NB_TIMEOUT-1:0] tmo_q, tmo_d;
    logic                fetch_ph_q, fetch_ph_d;
    logic                rx_pend_q;
    logic                done_q, done_d, error_q, error_d;
    logic                is_send, is_wait, byte_sent, rx_vld, tmo_exp;
    logic                bump, abort, start_byte;
    logic [7:0]          rx_byte, wbyte;

    assign is_send   = state_q inside {StSendHdr, StSendData, StSendCksum, StSendEot};
    assign is_wait   = state_q inside {StWaitNak, StWaitResp, StWaitEotAck};
    assign byte_sent = is_send && (tx_ph_q == TxWait) && i_uart_tx_done;
    // Every received byte is popped the cycle after its rx_done, whatever the state.
    assign rx_vld    = rx_pend_q;
    assign rx_byte   = i_uart_rx_data[7:0];
    assign tmo_exp   = is_wait && !rx_vld && (tmo_q == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));
    assign retry_inc = retry_q + 1'b1;

    assign o_uart_rd    = rx_pend_q;
    assign o_uart_wdata = NB_UART_DATA'(wbyte);
    assign o_busy       = (state_q != StIdle);
    assign o_done       = done_q;
    assign o_error      = error_q;

    always_comb begin
        state_d         = state_q;
        tx_ph_d         = tx_ph_q;
        base_d          = base_q;
        len_d           = len_q;
        blk_off_d       = blk_off_q;
        blk_d           = blk_q;
        idx_d           = idx_q;
        byte_d          = byte_q;
        cksum_d         = cksum_q;
        retry_d         = retry_q;
        fetch_ph_d      = fetch_ph_q;
        done_d          = 1'b0;
        error_d         = 1'b0;
        bump            = 1'b0;
        abort           = 1'b0;
        start_byte      = 1'b0;
        resend_st       = state_q;
        wbyte           = 8'h00;
        o_uart_wr       = 1'b0;
        o_uart_tx_start = 1'b0;
        o_src_addr      = '0;
        cur_off         = blk_off_q + NB_OFF'(idx_q);
        nxt_off         = '0;

        // Byte handshake: push, start, then hold until the shifter reports done.
        if (is_send) begin
            o_uart_wr       = (tx_ph_q == TxWr);
            o_uart_tx_start = (tx_ph_q == TxStart);
            case (tx_ph_q)
                TxWr:    tx_ph_d = TxStart;
                TxStart: tx_ph_d = TxWait;
                default: if (i_uart_tx_done) tx_ph_d = TxWr;
            endcase
        end

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    base_d    = i_base_addr;
                    len_d     = i_nbytes;
                    blk_d     = 8'h01;
                    retry_d   = '0;
                    blk_off_d = '0;
                    state_d   = StWaitNak;
                end
            end
            StWaitNak: begin
                if (rx_vld) begin
                    if (rx_byte == NAK) begin
                        retry_d = '0;
                        idx_d   = '0;
                        tx_ph_d = TxWr;
                        state_d = (len_q == '0) ? StSendEot : StSendHdr;
                    end else if (rx_byte == CAN) begin
                        abort = 1'b1;
                    end
                end else if (tmo_exp) begin
                    bump = 1'b1;
                end
            end
            StSendHdr: begin
                cksum_d = '0;
                wbyte   = (idx_q == 7'd0) ? SOH : (idx_q == 7'd1) ? blk_q : ~blk_q;
                if (byte_sent) begin
                    if (idx_q == 7'd2) begin
                        idx_d      = '0;
                        start_byte = 1'b1;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            StFetch: begin
                o_src_addr = base_q + NB_ADDR'(cur_off);
                if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    fetch_ph_d = 1'b0;
                    byte_d     = i_src_data;
                    state_d    = StSendData;
                end
            end
            StSendData: begin
                wbyte = byte_q;
                if (tx_ph_q == TxWr) cksum_d = cksum_q + byte_q;
                if (byte_sent) begin
                    if (idx_q == 7'd127) begin
                        idx_d   = '0;
                        state_d = StSendCksum;
                    end else begin
                        idx_d      = idx_q + 7'd1;
                        start_byte = 1'b1;
                    end
                end
            end
            StSendCksum: begin
                wbyte = cksum_q;
                if (byte_sent) state_d = StWaitResp;
            end
            StWaitResp: begin
                resend_st = StSendHdr;
                if (rx_vld) begin
                    if (rx_byte == ACK) begin
                        blk_d     = blk_q + 8'd1;
                        retry_d   = '0;
                        idx_d     = '0;
                        tx_ph_d   = TxWr;
                        blk_off_d = blk_off_q + NB_OFF'(128);
                        state_d   = (blk_off_d < NB_OFF'(len_q)) ? StSendHdr : StSendEot;
                    end else if (rx_byte == NAK) begin
                        bump = 1'b1;
                    end else if (rx_byte == CAN) begin
                        abort = 1'b1;
                    end
                end else if (tmo_exp) begin
                    bump = 1'b1;
                end
            end
            StSendEot: begin
                wbyte = EOT;
                if (byte_sent) state_d = StWaitEotAck;
            end
            StWaitEotAck: begin
                resend_st = StSendEot;
                if (rx_vld) begin
                    if (rx_byte == ACK) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else if (rx_byte == NAK) begin
                        bump = 1'b1;
                    end else if (rx_byte == CAN) begin
                        abort = 1'b1;
                    end
                end else if (tmo_exp) begin
                    bump = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Next payload byte: fetch from the source while in range, otherwise pad.
        if (start_byte) begin
            nxt_off = blk_off_q + NB_OFF'(idx_d);
            tx_ph_d = TxWr;
            if (nxt_off < NB_OFF'(len_q)) begin
                fetch_ph_d = 1'b0;
                state_d    = StFetch;
            end else begin
                byte_d  = PAD;
                state_d = StSendData;
            end
        end

        if (bump) begin
            if (retry_inc == NB_RETRY'(MAX_RETRY)) begin
                abort = 1'b1;
            end else begin
                retry_d = retry_inc;
                idx_d   = '0;
                tx_ph_d = TxWr;
                state_d = resend_st;
            end
        end

        if (abort) begin
            error_d = 1'b1;
            state_d = StIdle;
        end

        tmo_d = (is_wait && !rx_vld && !tmo_exp) ? tmo_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            tx_ph_q    <= TxWr;
            base_q     <= '0;
            len_q      <= '0;
            blk_off_q  <= '0;
            blk_q      <= 8'h01;
            idx_q      <= '0;
            byte_q     <= '0;
            cksum_q    <= '0;
            retry_q    <= '0;
            tmo_q      <= '0;
            fetch_ph_q <= 1'b0;
            rx_pend_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_ph_q    <= tx_ph_d;
            base_q     <= base_d;
            len_q      <= len_d;
            blk_off_q  <= blk_off_d;
            blk_q      <= blk_d;
            idx_q      <= idx_d;
            byte_q     <= byte_d;
            cksum_q    <= cksum_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            fetch_ph_q <= fetch_ph_d;
            rx_pend_q  <= i_uart_rx_done;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end
endmodule

// File: tb/tb_du_xmodem_tx.sv
// Bench for du_xmodem_tx: a table of complete transfers plus hand-written NAK resend,
// retry exhaustion, cancel, timeout and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_du_xmodem_tx;
    localparam int unsigned TMO = 1000;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam logic [7:0] CAN = 8'h18;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_base_addr = '0;
    logic [15:0] i_nbytes = '0;
    logic [15:0] o_src_addr;
    logic [7:0]  i_src_data;
    logic        o_uart_wr;
    logic [7:0]  o_uart_wdata;
    logic        o_uart_tx_start;
    logic        i_uart_tx_done = 1'b0;
    logic [7:0]  i_uart_rx_data = '0;
    logic        i_uart_rx_done = 1'b0;
    logic        o_uart_rd;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    always #5 clk = ~clk;

    du_xmodem_tx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .i_rst           (i_rst),
        .i_start         (i_start),
        .i_base_addr     (i_base_addr),
        .i_nbytes        (i_nbytes),
        .o_src_addr      (o_src_addr),
        .i_src_data      (i_src_data),
        .o_uart_wr       (o_uart_wr),
        .o_uart_wdata    (o_uart_wdata),
        .o_uart_tx_start (o_uart_tx_start),
        .i_uart_tx_done  (i_uart_tx_done),
        .i_uart_rx_data  (i_uart_rx_data),
        .i_uart_rx_done  (i_uart_rx_done),
        .o_uart_rd       (o_uart_rd),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error)
    );

    // Source bytes always have bit 7 set, so they can never be mistaken for 0x1A padding.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return {1'b1, a[6:0] ^ a[13:7]};
    endfunction

    always @(posedge clk) i_src_data <= src_byte(o_src_addr);

    // UART model and monitors.
    logic [7:0] tx_log[$];
    int done_cnt = 0, err_cnt = 0, rd_cnt = 0, viol = 0, addr_viol = 0;
    int tx_cnt = 0;
    bit inflight = 1'b0;
    int cur_base = 0, cur_len = 0;

    always @(negedge clk) begin
        if (i_rst) begin
            i_uart_tx_done = 1'b0;
            inflight       = 1'b0;
            tx_cnt         = 0;
        end else begin
            if (i_uart_tx_done) begin
                i_uart_tx_done = 1'b0;
                inflight       = 1'b0;
            end
            if (o_uart_wr) begin
                if (inflight) viol++;
                inflight = 1'b1;
                tx_log.push_back(o_uart_wdata);
            end
            if (o_uart_tx_start) begin
                tx_cnt = 3;
            end else if (tx_cnt != 0) begin
                tx_cnt--;
                if (tx_cnt == 0) i_uart_tx_done = 1'b1;
            end
            if (o_done) done_cnt++;
            if (o_error) err_cnt++;
            if (o_uart_rd) rd_cnt++;
            if (o_src_addr != 16'h0 &&
                (int'(o_src_addr) < cur_base || int'(o_src_addr) >= cur_base + cur_len))
                addr_viol++;
        end
    end

    int n_checks = 0, n_pass = 0;
    int t0 = 0, done0 = 0, err0 = 0, rd0 = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic int get_tx(input int i);
        if (t0 + i < tx_log.size()) return int'(tx_log[t0 + i]);
        return -1;
    endfunction

    // Golden XMODEM block: SOH, blk, ~blk, 128 payload bytes, 8-bit data sum.
    function automatic logic [7:0] exp_byte(input logic [15:0] base, input int len,
                                            input int bi, input int j);
        logic [7:0] blk, sum, d;
        int off;
        blk = 8'(bi + 1);
        sum = 8'h00;
        if (j == 0) return 8'h01;
        if (j == 1) return blk;
        if (j == 2) return ~blk;
        for (int i = 0; i < 128; i++) begin
            off = bi * 128 + i;
            d = (off < len) ? src_byte(base + 16'(off)) : 8'h1A;
            if (j == 3 + i) return d;
            sum = sum + d;
        end
        return sum;
    endfunction

    task automatic check_block(input string name, input int pos, input logic [15:0] base,
                               input int len, input int bi);
        int mism = 0;
        for (int j = 0; j < 132; j++)
            if (get_tx(pos + j) != int'(exp_byte(base, len, bi, j))) mism++;
        check(name, mism, 0);
    endtask

    task automatic wait_tx(input int n, input int budget, input int settle);
        int k = 0;
        while (tx_log.size() - t0 < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("tx_bytes_reached", int'(tx_log.size() - t0 >= n), 1);
        repeat (settle) @(negedge clk);
    endtask

    task automatic host_send(input logic [7:0] b);
        @(negedge clk);
        i_uart_rx_data = b;
        i_uart_rx_done = 1'b1;
        @(negedge clk);
        i_uart_rx_done = 1'b0;
    endtask

    task automatic start_xfer(input logic [15:0] base, input int len);
        @(negedge clk);
        cur_base    = int'(base);
        cur_len     = len;
        t0          = tx_log.size();
        done0       = done_cnt;
        err0        = err_cnt;
        rd0         = rd_cnt;
        i_start     = 1'b1;
        i_base_addr = base;
        i_nbytes    = 16'(len);
        @(negedge clk);
        i_start     = 1'b0;
        i_base_addr = 16'hFFFF;
        i_nbytes    = 16'hFFFF;
        check("busy_after_start", int'(o_busy), 1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cnt == done0 && err_cnt == err0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] base;
        int          len;
        int          nblk;
        int          pads;
    } xfer_t;

    task automatic run_xfer(input xfer_t v);
        int pads = 0;
        start_xfer(v.base, v.len);
        host_send(NAK);
        for (int b = 0; b < v.nblk; b++) begin
            wait_tx(132 * (b + 1), 5000, 8);
            check_block("block_bytes_wrong", 132 * b, v.base, v.len, b);
            host_send(ACK);
        end
        if (v.nblk > 0) begin
            for (int j = 3; j < 131; j++)
                if (get_tx(132 * (v.nblk - 1) + j) == 8'h1A) pads++;
            check("last_block_pad_count", pads, v.pads);
        end
        wait_tx(132 * v.nblk + 1, 5000, 8);
        check("eot_byte", get_tx(132 * v.nblk), 8'h04);
        host_send(ACK);
        wait_done();
        check("done_pulses", done_cnt - done0, 1);
        check("error_pulses", err_cnt - err0, 0);
        check("busy_after_done", int'(o_busy), 0);
        check("stream_length", int'(tx_log.size()) - t0, 132 * v.nblk + 1);
        check("rx_pops", rd_cnt - rd0, v.nblk + 2);
    endtask

    xfer_t vec[5];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{base: 16'h1000, len: 80,  nblk: 1, pads: 48};
        vec[1] = '{base: 16'h2000, len: 300, nblk: 3, pads: 84};
        vec[2] = '{base: 16'h0300, len: 128, nblk: 1, pads: 0};
        vec[3] = '{base: 16'h0400, len: 129, nblk: 2, pads: 127};
        vec[4] = '{base: 16'h0500, len: 0,   nblk: 0, pads: 0};

        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({o_uart_wr, o_uart_tx_start, o_uart_rd, o_busy, o_done, o_error,
                    |o_uart_wdata, |o_src_addr}), 0);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_not_busy", int'(o_busy), 0);

        // Reset in the middle of the payload, then a zero-length transfer.
        start_xfer(16'h1000, 80);
        host_send(NAK);
        wait_tx(20, 5000, 0);
        i_rst = 1'b1;
        @(negedge clk);
        check("midreset_outputs",
              int'({o_uart_wr, o_uart_tx_start, o_uart_rd, o_busy, o_done, o_error,
                    |o_uart_wdata, |o_src_addr}), 0);
        i_rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midreset_no_error", err_cnt - err0, 0);
        run_xfer(vec[4]);

        foreach (vec[i]) run_xfer(vec[i]);

        // NAK after the first block: identical block resent, then EOT.
        start_xfer(16'h1000, 80);
        host_send(NAK);
        wait_tx(132, 5000, 8);
        host_send(NAK);
        wait_tx(264, 5000, 8);
        check_block("resent_block_bytes_wrong", 132, 16'h1000, 80, 0);
        host_send(ACK);
        wait_tx(265, 5000, 8);
        check("eot_after_resend", get_tx(264), 8'h04);
        host_send(ACK);
        wait_done();
        check("done_after_resend", done_cnt - done0, 1);

        // Ten NAKs on block 1: abort without EOT.
        start_xfer(16'h1000, 80);
        host_send(NAK);
        for (int k = 1; k <= 10; k++) begin
            wait_tx(132 * k, 5000, 8);
            host_send(NAK);
        end
        repeat (10) @(negedge clk);
        check("nak_abort_error", err_cnt - err0, 1);
        check("nak_abort_no_done", done_cnt - done0, 0);
        check("nak_abort_stream", int'(tx_log.size()) - t0, 1320);
        check("nak_abort_idle", int'(o_busy), 0);

        // CAN while waiting for the block response aborts right away.
        start_xfer(16'h1000, 80);
        host_send(NAK);
        wait_tx(132, 5000, 8);
        host_send(CAN);
        @(negedge clk);
        check("can_error_now", int'(o_error), 1);
        check("can_busy_low", int'(o_busy), 0);
        repeat (5) @(negedge clk);
        check("can_error_pulses", err_cnt - err0, 1);
        check("can_stream", int'(tx_log.size()) - t0, 132);

        // Silent host: block resent after each timeout, abort after ten sends.
        start_xfer(16'h3000, 80);
        host_send(NAK);
        wait_tx(132, 5000, 8);
        repeat (900) @(negedge clk);
        check("no_early_resend", int'(tx_log.size()) - t0, 132);
        wait_tx(264, 3000, 0);
        check_block("timeout_resend_bytes_wrong", 132, 16'h3000, 80, 0);
        for (int k = 0; k < 25000 && err_cnt == err0; k++) @(negedge clk);
        check("timeout_abort_error", err_cnt - err0, 1);
        check("timeout_abort_stream", int'(tx_log.size()) - t0, 1320);

        check("one_byte_in_flight", viol, 0);
        check("source_addr_range", addr_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/du_xmodem_tx.md
# du_xmodem_tx

XMODEM (checksum variant) transmitter for the debug unit: streams a byte range from a synchronous-read source (data memory / register dump port) to the host over UART0 as 128-byte SOH blocks. It is the counterpart of the debug unit's XMODEM receive path used for program load. It sits between the debug-unit control FSM (start/length, done/error) and the `uart_top` TX FIFO / RX FIFO ports; ACK/NAK/CAN from the host arrive over the same UART.

## Interface
Parameters:
- `NB_UART_DATA`, 8, UART byte width
- `NB_ADDR`, 16, source byte-address width
- `NB_LEN`, 16, transfer-length width (bytes)
- `MAX_RETRY`, 10, NAKs/timeouts tolerated per block before abort
- `NB_TIMEOUT`, 32, timeout counter width
- `TIMEOUT_CYCLES`, 100000000, clk cycles waiting for a response byte before it counts as a NAK

Ports (one clock `clk`; reset `i_rst` is synchronous, active-high):
- `clk` in 1: clock
- `i_rst` in 1: synchronous active-high reset
- `i_start` in 1: one-cycle request; ignored unless idle
- `i_base_addr` in NB_ADDR: first source byte address, sampled on accepted `i_start`
- `i_nbytes` in NB_LEN: payload length, sampled on accepted `i_start`
- `o_src_addr` out NB_ADDR: source read address
- `i_src_data` in 8: source byte, valid 1 cycle after `o_src_addr`
- `o_uart_wr` out 1: push `o_uart_wdata` into TX FIFO
- `o_uart_wdata` out NB_UART_DATA: byte to transmit
- `o_uart_tx_start` out 1: start transmission of FIFO head
- `i_uart_tx_done` in 1: one-cycle pulse, byte fully shifted out
- `i_uart_rx_data` in NB_UART_DATA: RX FIFO head
- `i_uart_rx_done` in 1: one-cycle pulse, byte received into RX FIFO
- `o_uart_rd` out 1: pop RX FIFO
- `o_busy` out 1: transfer in progress
- `o_done` out 1: one-cycle pulse, EOT acknowledged
- `o_error` out 1: one-cycle pulse, transfer aborted

## Operation
- States: IDLE, WAIT_NAK, SEND_HDR, FETCH, SEND_DATA, SEND_CKSUM, WAIT_RESP, SEND_EOT, WAIT_EOT_ACK.
- IDLE: on `i_start` latch base/length, blk=0x01, retry=0, go WAIT_NAK, `o_busy`=1.
- WAIT_NAK: receiver-initiated; wait for 0x15 (NAK); other bytes popped and discarded. 0x18 (CAN) → abort. Timeout → retry++.
- SEND_HDR: bytes 0x01, blk, ~blk. Checksum cleared.
- Per data byte i (0..127) of block: offset = (blk_index*128)+i; if offset < length: FETCH drives `o_src_addr`=base+offset, byte=`i_src_data` next cycle; else byte=0x1A (no read). Checksum += byte (mod 256, data bytes only).
- SEND_CKSUM: checksum byte, then WAIT_RESP.
- WAIT_RESP: 0x06 (ACK) → blk++ (8-bit wrap 0xFF→0x00), retry=0; next block if offset < length else SEND_EOT. 0x15 or timeout → retry++, resend same block from SEND_HDR (same blk, same data re-read). 0x18 → abort. Other bytes discarded.
- retry reaching MAX_RETRY → abort.
- SEND_EOT: byte 0x04; WAIT_EOT_ACK: 0x06 → `o_done`, IDLE; 0x15/timeout → resend EOT (retry rules apply); 0x18 → abort.
- Abort: `o_error` pulse, IDLE; no EOT sent.
- Length 0: after initial NAK send EOT only. Blocks = ceil(length/128).

## Timing
- Reset: all outputs 0, state IDLE, blk=0x01, checksum=0, counters 0. `i_rst` mid-transfer aborts silently (no `o_error`).
- Byte send handshake: cycle N `o_uart_wr`=1 with `o_uart_wdata`; N+1 `o_uart_tx_start`=1; then hold until `i_uart_tx_done`; next byte's `o_uart_wr` no earlier than the cycle after `i_uart_tx_done`. Exactly one byte in flight.
- Fetch: address issued one cycle, data captured next cycle, `o_uart_wr` the cycle after capture.
- Receive: on `i_uart_rx_done` in cycle N, `i_uart_rx_data` sampled in N+1 and `o_uart_rd`=1 in N+1 (single pop per byte). Bytes received outside WAIT_* states are popped and ignored.
- Timeout counter restarts on entry to each WAIT_* state; expires after TIMEOUT_CYCLES without a received byte.
- `o_done`/`o_error` asserted the cycle IDLE is re-entered; `o_busy` low that same cycle. `i_start` during `o_busy` ignored.

## Test plan
- 80-byte dump (source = 20 instruction words), host sends 0x15 → UART shows 01 01 FE, 80 source bytes, 48×1A, checksum = sum mod 256, host 06 → 04, host 06 → one `o_done` pulse, `o_busy` 0.
- NAK after first block → identical 132-byte block resent with blk 01/FE; ACK → EOT.
- 300-byte dump → blocks 01/FE, 02/FD, 03/FC; third block 44 data + 84×1A; no source reads beyond base+299.
- 10 consecutive NAKs on block 1 → `o_error` pulse, no 0x04 transmitted; host 0x18 in WAIT_RESP → immediate `o_error`.
- No response with TIMEOUT_CYCLES=1000 → block resent every ~1000 cycles, abort after 10.
- `i_rst` during SEND_DATA → all outputs 0 next cycle; following `i_start` with `i_nbytes`=0, host NAK → only 0x04, ACK → `o_done`.
